fwd_hazard_ctrl: RTL and testbench

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control for a 5-stage pipeline.
// Tracks the EX/MEM/WB destination entries and steers operand bypass muxes.
module fwd_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_ra,
  input  logic [2:0]  id_rb,
  input  logic        id_ra_used,
  input  logic        id_rb_used,
  input  logic [2:0]  id_rd,
  input  logic        id_wr_en,
  input  logic [1:0]  id_src,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [1:0]  m3_mem,
  output logic [15:0] stall_cnt
);

  localparam int unsigned REG_W = 3;
  localparam int unsigned SRC_W = 2;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [SRC_W-1:0] SRC_LOAD = 2'b00;

  localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EX  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'b10;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr_en;
    logic [SRC_W-1:0] src;
  } stage_t;

  stage_t           ex_q;
  stage_t           mem_q;
  stage_t           wb_q;
  stage_t           id_ent;
  stage_t           ex_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic ex_a, mem_a, wb_a;
  logic ex_b, mem_b, wb_b;
  logic haz_a, haz_b;
  logic [SEL_W-1:0] sel_a, sel_b;

  // A stage produces operand r when it is live, writes, and targets r.
  function automatic logic produces(input stage_t s, input logic [REG_W-1:0] r,
                                    input logic used);
    return used & s.valid & s.wr_en & (s.rd == r);
  endfunction

  // Youngest non-load producer wins; WB data is always final.
  function automatic logic [SEL_W-1:0] pick_sel(input logic ex_m, input logic mem_m,
                                                input logic wb_m);
    logic [SEL_W-1:0] sel;
    sel = SEL_RF;
    if (ex_m && (ex_q.src != SRC_LOAD))
      sel = SEL_EX;
    else if (mem_m && (mem_q.src != SRC_LOAD))
      sel = SEL_MEM;
    else if (wb_m)
      sel = SEL_WB;
    return sel;
  endfunction

  // Load data is not available until WB; a younger EX writer shadows MEM.
  function automatic logic load_hazard(input logic ex_m, input logic mem_m);
    return (ex_m && (ex_q.src == SRC_LOAD)) ||
           (!ex_m && mem_m && (mem_q.src == SRC_LOAD));
  endfunction

  always_comb begin
    id_ent       = '0;
    id_ent.valid = id_valid;
    id_ent.rd    = id_rd;
    id_ent.wr_en = id_wr_en;
    id_ent.src   = id_src;
  end

  always_comb begin
    ex_a  = produces(ex_q,  id_ra, id_ra_used);
    mem_a = produces(mem_q, id_ra, id_ra_used);
    wb_a  = produces(wb_q,  id_ra, id_ra_used);
    ex_b  = produces(ex_q,  id_rb, id_rb_used);
    mem_b = produces(mem_q, id_rb, id_rb_used);
    wb_b  = produces(wb_q,  id_rb, id_rb_used);
  end

  always_comb begin
    haz_a = load_hazard(ex_a, mem_a);
    haz_b = load_hazard(ex_b, mem_b);
    sel_a = pick_sel(ex_a, mem_a, wb_a);
    sel_b = pick_sel(ex_b, mem_b, wb_b);
  end

  // Flush kills the ID instruction, so it can never be the one held.
  always_comb begin
    stall     = id_valid & ~flush & (haz_a | haz_b);
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (id_valid && !stall) begin
      fwd_a_sel = sel_a;
      fwd_b_sel = sel_b;
    end
    m3_mem = mem_q.valid ? mem_q.src : SRC_LOAD;
  end

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall && !flush)
      ex_d = id_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // Saturating count of bubble cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus random traffic against
// a reference that searches an in-flight instruction list by age.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  id_ra, id_rb, id_rd;
  logic        id_ra_used, id_rb_used, id_wr_en;
  logic [1:0]  id_src;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel, m3_mem;
  logic [15:0] stall_cnt;

  fwd_hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_ra      (id_ra),
    .id_rb      (id_rb),
    .id_ra_used (id_ra_used),
    .id_rb_used (id_rb_used),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_src     (id_src),
    .flush      (flush),
    .stall      (stall),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .m3_mem     (m3_mem),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [2:0] rd;
    bit       we;
    bit [1:0] src;
  } ent_t;

  // in_flight[0] is the youngest (EX), [1] MEM, [2] WB.
  ent_t        in_flight [3];
  int unsigned m_cnt;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] cnt_hold;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input ent_t e, input bit [2:0] r, input bit used);
    return used && e.v && e.we && (e.rd == r);
  endfunction

  // Hazard: nearest writer is still a load not yet in WB.
  // Select: first writer by age whose data exists at that stage (WB always does).
  task automatic model_operand(input bit [2:0] r, input bit used,
                               output bit haz, output bit [1:0] sel);
    int  nearest;
    bit  found;
    nearest = -1;
    for (int d = 2; d >= 0; d--)
      if (writes(in_flight[d], r, used)) nearest = d;
    haz = (nearest == 0 || nearest == 1) && (in_flight[nearest].src == 2'b00);
    sel   = 2'b00;
    found = 1'b0;
    for (int d = 0; d < 3; d++)
      if (!found && writes(in_flight[d], r, used) && (in_flight[d].src != 2'b00 || d == 2)) begin
        sel   = 2'(d + 1);
        found = 1'b1;
      end
  endtask

  task automatic model_outputs(output bit st, output bit [1:0] sa, output bit [1:0] sb,
                               output bit [1:0] m3);
    bit ha, hb;
    bit [1:0] a0, b0;
    model_operand(id_ra, id_ra_used, ha, a0);
    model_operand(id_rb, id_rb_used, hb, b0);
    st = id_valid && !flush && (ha || hb);
    sa = (st || !id_valid) ? 2'b00 : a0;
    sb = (st || !id_valid) ? 2'b00 : b0;
    m3 = in_flight[1].v ? in_flight[1].src : 2'b00;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) in_flight[d] = '{default: 0};
    m_cnt = 0;
  endtask

  task automatic model_advance(input bit st);
    ent_t n;
    n = '{default: 0};
    if (id_valid && !st && !flush) n = '{1'b1, id_rd, id_wr_en, id_src};
    in_flight[2] = in_flight[1];
    in_flight[1] = in_flight[0];
    in_flight[0] = n;
    if (st && m_cnt < 32'hFFFF) m_cnt++;
  endtask

  task automatic set_id(input bit v, input bit [2:0] ra, input bit ua, input bit [2:0] rb,
                        input bit ub, input bit [2:0] rd, input bit we, input bit [1:0] src);
    id_valid = v; id_ra = ra; id_ra_used = ua; id_rb = rb; id_rb_used = ub;
    id_rd = rd; id_wr_en = we; id_src = src;
  endtask

  task automatic idle();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'b00);
  endtask

  // Compare all outputs with the reference, then clock one cycle.
  task automatic cycle();
    bit st;
    bit [1:0] sa, sb, m3;
    #1;
    model_outputs(st, sa, sb, m3);
    chk("stall",     16'(stall),     16'(st));
    chk("fwd_a_sel", 16'(fwd_a_sel), 16'(sa));
    chk("fwd_b_sel", 16'(fwd_b_sel), 16'(sb));
    chk("m3_mem",    16'(m3_mem),    16'(m3));
    chk("stall_cnt", stall_cnt,      16'(m_cnt));
    @(posedge clk);
    model_advance(st);
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (3) cycle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, 16'(stall),     16'h0);
    chk({tag, "_fa"},    16'(fwd_a_sel), 16'h0);
    chk({tag, "_fb"},    16'(fwd_b_sel), 16'h0);
    chk({tag, "_m3"},    16'(m3_mem),    16'h0);
    chk({tag, "_cnt"},   stall_cnt,      16'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("post_reset");

    // ALU result consumed back-to-back comes from EX.
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 2'b01); cycle();
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 2'b01);
    #1;
    chk("alu_b2b_fa", 16'(fwd_a_sel), 16'h1);
    chk("alu_b2b_stall", 16'(stall), 16'h0);
    cycle();
    drain();

    // Load-use: two bubbles, then WB forward.
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 2'b00); cycle();
    set_id(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd1, 1'b1, 2'b01);
    #1; chk("ld_use_st1", 16'(stall), 16'h1); cycle();
    #1; chk("ld_use_st2", 16'(stall), 16'h1); cycle();
    #1; chk("ld_use_st3", 16'(stall), 16'h0);
    chk("ld_use_fb", 16'(fwd_b_sel), 16'h3);
    cycle();
    idle();
    #1; chk("ld_use_cnt", stall_cnt, 16'd2);
    drain();

    // EX beats MEM; with EX empty, MEM shifter result is used.
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 2'b10); cycle();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 2'b01); cycle();
    set_id(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 2'b01);
    #1; chk("prio_ex", 16'(fwd_a_sel), 16'h1);
    cycle();
    drain();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 2'b10); cycle();
    idle(); cycle();
    set_id(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 2'b01);
    #1; chk("prio_mem", 16'(fwd_a_sel), 16'h2);
    cycle();
    drain();

    // Flush during a load-use stall.
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 2'b00); cycle();
    set_id(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 2'b01);
    #1; chk("flush_pre_st", 16'(stall), 16'h1); cycle();
    flush = 1'b1;
    #1; chk("flush_st", 16'(stall), 16'h0);
    cnt_hold = stall_cnt;
    cycle();
    flush = 1'b0;
    #1; chk("flush_cnt", stall_cnt, cnt_hold);
    chk("flush_cnt_abs", stall_cnt, 16'd3);
    chk("flush_ex_bubble", 16'(fwd_a_sel), 16'h3);
    cycle();
    drain();

    // PC+1 result sitting in MEM.
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 2'b11); cycle();
    idle(); cycle();
    set_id(1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0, 2'b01);
    #1; chk("pc1_m3", 16'(m3_mem), 16'h3);
    chk("pc1_fb", 16'(fwd_b_sel), 16'h2);
    cycle();
    drain();

    // Random traffic on a narrow register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 99) < 85, 3'($urandom_range(0, 3)), 1'($urandom),
             3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, 2'($urandom));
      flush = ($urandom_range(0, 9) == 0);
      cycle();
    end
    flush = 1'b0;
    drain();

    // Counter saturation from a preloaded value.
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFD;
    repeat (2) begin
      set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 2'b00); cycle();
      set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 2'b01); cycle(); cycle();
      idle(); cycle();
    end
    #1; chk("sat_cnt", stall_cnt, 16'hFFFF);

    // Reset asserted while stalled.
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 2'b00); cycle();
    set_id(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 2'b01);
    #1; chk("rst_pre_st", 16'(stall), 16'h1);
    rst_n = 1'b0;
    model_reset();
    #1; check_all_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1; check_all_zero("rst_rel");
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
